// File: rtl/tile_bank_router.sv
// Multi-port address router: classifies each port's address against the SRAM
// region, maps it to bank/offset, and arbitrates same-bank conflicts round-robin.
module tile_bank_router #(
    parameter int ADDR_BITS   = 16,
    parameter int NUM_PORTS   = 4,
    parameter int NUM_BANKS   = 8,
    parameter int BANK_DEPTH  = 256,
    parameter int BANK_BITS   = $clog2(NUM_BANKS),
    parameter int OFFSET_BITS = $clog2(BANK_DEPTH)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             mode,
    input  logic [ADDR_BITS-1:0]             sram_base,
    input  logic [ADDR_BITS-1:0]             sram_limit,
    input  logic [NUM_PORTS-1:0]             in_valid,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]   in_addr,
    output logic [NUM_PORTS-1:0]             in_ready,
    output logic [NUM_PORTS-1:0]             out_valid,
    input  logic [NUM_PORTS-1:0]             out_ready,
    output logic [NUM_PORTS*BANK_BITS-1:0]   out_bank,
    output logic [NUM_PORTS*OFFSET_BITS-1:0] out_offset,
    output logic [NUM_PORTS*2-1:0]           out_kind,
    output logic [15:0]                      conflict_count
);

    localparam int PTR_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_BITS:0] CAPACITY =
        (ADDR_BITS+1)'(NUM_BANKS * BANK_DEPTH);
    localparam logic [1:0] KIND_SRAM  = 2'b00;
    localparam logic [1:0] KIND_EXT   = 2'b01;
    localparam logic [1:0] KIND_FAULT = 2'b10;

    logic [NUM_PORTS-1:0][ADDR_BITS-1:0]   addr_c;
    logic [NUM_PORTS-1:0][ADDR_BITS-1:0]   local_c;
    logic [NUM_PORTS-1:0][1:0]             kind_c;
    logic [NUM_PORTS-1:0][BANK_BITS-1:0]   bank_c;
    logic [NUM_PORTS-1:0][OFFSET_BITS-1:0] off_c;

    logic [NUM_PORTS-1:0] slot_free;
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] lost;

    logic [NUM_PORTS-1:0]                  valid_q;
    logic [NUM_PORTS-1:0][1:0]             kind_q;
    logic [NUM_PORTS-1:0][BANK_BITS-1:0]   bank_q;
    logic [NUM_PORTS-1:0][OFFSET_BITS-1:0] off_q;
    logic [PTR_BITS-1:0]                   rr_q;
    logic [PTR_BITS-1:0]                   rr_d;
    logic [15:0]                           cnt_q;
    logic [15:0]                           cnt_d;

    // Distance from the round-robin pointer; smaller means higher priority.
    function automatic int prio(input int p, input int rr);
        return (p + NUM_PORTS - rr) % NUM_PORTS;
    endfunction

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign addr_c[g]  = in_addr[g*ADDR_BITS +: ADDR_BITS];
        assign local_c[g] = addr_c[g] - sram_base;

        always_comb begin
            kind_c[g] = KIND_SRAM;
            bank_c[g] = '0;
            off_c[g]  = '0;
            if (addr_c[g] < sram_base) begin
                kind_c[g] = KIND_FAULT;
            end else if (addr_c[g] > sram_limit) begin
                kind_c[g] = KIND_EXT;
            end else if ({1'b0, local_c[g]} >= CAPACITY) begin
                kind_c[g] = KIND_FAULT;
            end else if (!mode) begin
                bank_c[g] = local_c[g][BANK_BITS-1:0];
                off_c[g]  = local_c[g][BANK_BITS +: OFFSET_BITS];
            end else begin
                off_c[g]  = local_c[g][OFFSET_BITS-1:0];
                bank_c[g] = local_c[g][OFFSET_BITS +: BANK_BITS];
            end
        end

        assign slot_free[g] = !valid_q[g] || out_ready[g];
        assign cand[g] = in_valid[g] && slot_free[g]
                         && (kind_c[g] == KIND_SRAM);
    end

    always_comb begin
        lost = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (i != j && cand[i] && cand[j]
                    && bank_c[i] == bank_c[j]
                    && prio(j, int'(rr_q)) < prio(i, int'(rr_q))) begin
                    lost[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = slot_free & ~lost;

    always_comb begin
        rr_d  = rr_q;
        cnt_d = cnt_q;
        if (|lost) begin
            if (rr_q == PTR_BITS'(NUM_PORTS - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = rr_q + 1'b1;
            end
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            kind_q  <= '0;
            bank_q  <= '0;
            off_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    valid_q[i] <= 1'b1;
                    kind_q[i]  <= kind_c[i];
                    bank_q[i]  <= bank_c[i];
                    off_q[i]   <= off_c[i];
                end else if (out_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_kind       = kind_q;
    assign out_bank       = bank_q;
    assign out_offset     = off_q;
    assign conflict_count = cnt_q;

endmodule

// File: tb/tb_tile_bank_router.sv
// Bench for tile_bank_router: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_tile_bank_router;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [15:0] sram_base;
    logic [15:0] sram_limit;
    logic [3:0]  in_valid;
    logic [63:0] in_addr;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [11:0] out_bank;
    logic [31:0] out_offset;
    logic [7:0]  out_kind;
    logic [15:0] conflict_count;

    tile_bank_router dut (
        .clk(clk), .reset(reset), .mode(mode),
        .sram_base(sram_base), .sram_limit(sram_limit),
        .in_valid(in_valid), .in_addr(in_addr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bank(out_bank), .out_offset(out_offset),
        .out_kind(out_kind), .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    bit   mv[4];
    int   mk[4], mb[4], mo[4];
    int   rr, cnt;
    int   checks = 0, failures = 0;
    logic [3:0] rdy_seen;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void classify(input int a, output int k,
                                     output int b, output int o);
        int base = int'(sram_base);
        int lim  = int'(sram_limit);
        int loc;
        k = 0; b = 0; o = 0;
        if (a < base) k = 2;
        else if (a > lim) k = 1;
        else begin
            loc = a - base;
            if (loc >= 8 * 256) k = 2;
            else if (mode == 1'b0) begin
                b = loc % 8;
                o = (loc / 8) % 256;
            end else begin
                o = loc % 256;
                b = (loc / 256) % 8;
            end
        end
    endfunction

    function automatic int port_addr(input int p);
        return int'(in_addr[p*16 +: 16]);
    endfunction

    // Walk ports in priority order; first claimant of a bank wins it.
    task automatic model_ready(output logic [3:0] rdy, output bit any_lost);
        bit taken[8];
        int k, b, o, p;
        bit free;
        for (int i = 0; i < 8; i++) taken[i] = 0;
        any_lost = 0;
        rdy = '0;
        for (int s = 0; s < 4; s++) begin
            p = (rr + s) % 4;
            free = !mv[p] || out_ready[p];
            rdy[p] = free;
            classify(port_addr(p), k, b, o);
            if (in_valid[p] && free && k == 0) begin
                if (taken[b]) begin
                    rdy[p] = 1'b0;
                    any_lost = 1;
                end else begin
                    taken[b] = 1;
                end
            end
        end
    endtask

    task automatic step();
        logic [3:0]  rdy;
        logic [7:0]  ek;
        logic [11:0] eb;
        logic [31:0] eo;
        logic [3:0]  ev;
        bit al;
        int k, b, o;
        model_ready(rdy, al);
        #1;
        rdy_seen = in_ready;
        if (!reset) check("in_ready", in_ready, rdy);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mv[i] = 0; mk[i] = 0; mb[i] = 0; mo[i] = 0;
            end
            rr = 0; cnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && rdy[i]) begin
                    classify(port_addr(i), k, b, o);
                    mv[i] = 1; mk[i] = k; mb[i] = b; mo[i] = o;
                end else if (out_ready[i]) begin
                    mv[i] = 0;
                end
            end
            if (al) begin
                rr = (rr + 1) % 4;
                if (cnt < 65535) cnt++;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ev[i] = mv[i];
            ek[i*2 +: 2] = 2'(mk[i]);
            eb[i*3 +: 3] = 3'(mb[i]);
            eo[i*8 +: 8] = 8'(mo[i]);
        end
        check("out_valid", out_valid, ev);
        check("out_kind", out_kind, ek);
        check("out_bank", out_bank, eb);
        check("out_offset", out_offset, eo);
        check("conflict_count", conflict_count, 16'(cnt));
    endtask

    task automatic set_addr(input int p, input logic [15:0] a);
        in_addr[p*16 +: 16] = a;
    endtask

    int region;

    initial begin
        reset = 1'b1; mode = 1'b0;
        sram_base = 16'h0100; sram_limit = 16'h08FF;
        in_valid = '0; in_addr = '0; out_ready = 4'hF;
        rr = 0; cnt = 0;
        for (int i = 0; i < 4; i++) begin
            mv[i] = 0; mk[i] = 0; mb[i] = 0; mo[i] = 0;
        end
        step();
        step();
        check("rst_valid", out_valid, 4'h0);
        check("rst_count", conflict_count, 16'h0);
        reset = 1'b0;

        // Parallel, different banks
        in_valid = 4'b0011;
        set_addr(0, 16'h0100); set_addr(1, 16'h0101);
        step();
        check("par_ready", rdy_seen[1:0], 2'b11);
        check("par_bank", out_bank[5:0], {3'd1, 3'd0});
        check("par_off", out_offset[15:0], 16'h0);
        check("par_kind", out_kind[3:0], 4'h0);
        check("par_cnt", conflict_count, 16'd0);

        // Conflict on bank 0, rr at 0
        in_valid = 4'b0101;
        set_addr(0, 16'h0108); set_addr(2, 16'h0110);
        step();
        check("cf_ready", rdy_seen, 4'b1011);
        check("cf_cnt", conflict_count, 16'd1);
        in_valid = 4'b0100;
        step();
        check("cf_retry_rdy", rdy_seen[2], 1'b1);
        check("cf_retry_v", out_valid, 4'b0100);
        check("cf_retry_off", out_offset[23:16], 8'h02);

        // Blocked mode
        mode = 1'b1; in_valid = 4'b1000; set_addr(3, 16'h0405);
        step();
        check("blk_bank", out_bank[11:9], 3'd3);
        check("blk_off", out_offset[31:24], 8'h05);
        check("blk_kind", out_kind[7:6], 2'b00);
        mode = 1'b0; sram_base = 16'h0000; sram_limit = 16'hFFFF;
        in_valid = 4'b0001; set_addr(0, 16'h0800);
        step();
        check("cap_kind", out_kind[1:0], 2'b10);

        // Fault below region, external above
        sram_base = 16'h0100; sram_limit = 16'h08FF;
        in_valid = 4'b0011;
        set_addr(0, 16'h00FF); set_addr(1, 16'h0900);
        step();
        check("rgn_ready", rdy_seen[1:0], 2'b11);
        check("rgn_kind", out_kind[3:0], 4'b0110);
        check("rgn_bank", out_bank[5:0], 6'h0);
        check("rgn_off", out_offset[15:0], 16'h0);
        check("rgn_cnt", conflict_count, 16'd1);

        // Backpressure then drain+capture
        in_valid = 4'b0001; set_addr(0, 16'h0123);
        step();
        out_ready = 4'b1110; set_addr(0, 16'h0200);
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_ready", rdy_seen[0], 1'b0);
            check("bp_valid", out_valid[0], 1'b1);
            check("bp_bank", out_bank[2:0], 3'd3);
            check("bp_off", out_offset[7:0], 8'h04);
        end
        out_ready = 4'hF;
        step();
        check("dc_ready", rdy_seen[0], 1'b1);
        check("dc_valid", out_valid[0], 1'b1);
        check("dc_off", out_offset[7:0], 8'h20);

        // Advance rr to 2, fill all slots, then reset
        in_valid = 4'b0011;
        set_addr(0, 16'h0100); set_addr(1, 16'h0108);
        step();
        check("rr1_ready", rdy_seen[1:0], 2'b10);
        in_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_addr(i, 16'(16'h0100 + i));
        step();
        out_ready = 4'h0; in_valid = 4'h0;
        step();
        check("full_valid", out_valid, 4'hF);
        reset = 1'b1;
        step();
        check("mrst_valid", out_valid, 4'h0);
        check("mrst_cnt", conflict_count, 16'd0);
        reset = 1'b0; out_ready = 4'hF; in_valid = 4'b0011;
        set_addr(0, 16'h0100); set_addr(1, 16'h0108);
        step();
        check("mrst_rr0", rdy_seen, 4'b1101);

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            if (c % 60 == 0) begin
                region = int'($urandom_range(0, 3));
                sram_base = (region == 2) ? 16'h8000 : 16'h0100;
                case (region)
                    0: sram_limit = sram_base + 16'h07FF;
                    1: sram_limit = sram_base + 16'h0FFF;
                    2: sram_limit = 16'hFFFF;
                    default: sram_limit = sram_base - 16'd1;
                endcase
            end
            reset = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            in_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) out_ready[i] = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: set_addr(i, 16'(sram_base + 16'($urandom_range(0, 15) << 3)));
                    1: set_addr(i, 16'(sram_base + 16'($urandom_range(0, 7) << 8)));
                    2: set_addr(i, 16'($urandom));
                    default: set_addr(i, 16'(sram_base + 16'($urandom_range(0, 16'h1000))));
                endcase
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
